// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// An entry is one pending register write: {rd, data}.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  localparam int ENTRY_W = REG_AW + XLEN;

  function automatic logic entry_hits(input wb_entry_t e, input logic [REG_AW-1:0] addr);
    return (e.rd == addr);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer, register-file write and hazard-query signals of the write-back arbiter.
// slave is the arbiter side, master is the side that drives producers and queries.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                alu_valid;
  logic [REG_AW-1:0]   alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                alu_ready;
  logic                ld_valid;
  logic [REG_AW-1:0]   ld_rd;
  logic [XLEN-1:0]     ld_data;
  logic                ld_ready;
  logic                rg_wrt_en;
  logic [REG_AW-1:0]   rg_wrt_addr;
  logic [XLEN-1:0]     rg_wrt_data;
  logic [REG_AW-1:0]   query_addr;
  logic                query_hit;
  logic                busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, query_addr,
    output alu_ready, ld_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, query_hit, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, query_addr,
    input  alu_ready, ld_ready, rg_wrt_en, rg_wrt_addr, rg_wrt_data, query_hit, busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-source result FIFO; exposes every slot and its occupancy so the
// top level can match pending destinations against a hazard query.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output wb_entry_t               head,
  output wb_entry_t [DEPTH-1:0]   slots,
  output logic [DEPTH-1:0]        slot_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  // Push is refused when full even if a pop happens the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign slots   = mem;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful under slot_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole write-port master of the integer register file: merges ALU and load
// results, one write per cycle, LSU priority with an ALU anti-starvation override.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t               alu_head, ld_head, win;
  wb_entry_t [DEPTH-1:0]   alu_slots, ld_slots;
  logic [DEPTH-1:0]        alu_slot_valid, ld_slot_valid;
  logic                    alu_full, alu_empty, ld_full, ld_empty;
  logic                    grant_any, grant_src;
  logic [SW-1:0]           starve_cnt;
  logic                    wrt_en;
  logic [REG_AW-1:0]       wrt_addr;
  logic [XLEN-1:0]         wrt_data;
  logic                    pending_hit;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.alu_valid),
    .push_entry ({bus.alu_rd, bus.alu_data}),
    .pop        (grant_any && (grant_src == SRC_ALU)),
    .full       (alu_full),
    .empty      (alu_empty),
    .head       (alu_head),
    .slots      (alu_slots),
    .slot_valid (alu_slot_valid)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.ld_valid),
    .push_entry ({bus.ld_rd, bus.ld_data}),
    .pop        (grant_any && (grant_src == SRC_LSU)),
    .full       (ld_full),
    .empty      (ld_empty),
    .head       (ld_head),
    .slots      (ld_slots),
    .slot_valid (ld_slot_valid)
  );

  // Winner selection on the FIFO heads.
  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_LSU;
    win       = ld_head;
    if (!alu_empty && (ld_empty || (starve_cnt == SW'(STARVE_LIMIT)))) begin
      grant_any = 1'b1;
      grant_src = SRC_ALU;
      win       = alu_head;
    end else if (!ld_empty) begin
      grant_any = 1'b1;
      grant_src = SRC_LSU;
      win       = ld_head;
    end else begin
      grant_any = 1'b0;
      grant_src = SRC_LSU;
      win       = ld_head;
    end
  end

  // Counts consecutive cycles a waiting ALU head loses; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= {SW{1'b0}};
    end else if (alu_empty || (grant_any && (grant_src == SRC_ALU))) begin
      starve_cnt <= {SW{1'b0}};
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Output register: x0 entries load addr/data but never raise the enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrt_en   <= 1'b0;
      wrt_addr <= {REG_AW{1'b0}};
      wrt_data <= {XLEN{1'b0}};
    end else if (grant_any) begin
      wrt_en   <= (win.rd != {REG_AW{1'b0}});
      wrt_addr <= win.rd;
      wrt_data <= win.data;
    end else begin
      wrt_en   <= 1'b0;
    end
  end

  // Any live FIFO slot targeting the queried register.
  always_comb begin
    pending_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_hit = pending_hit
                  | (alu_slot_valid[i] & entry_hits(alu_slots[i], bus.query_addr))
                  | (ld_slot_valid[i]  & entry_hits(ld_slots[i],  bus.query_addr));
    end
  end

  assign bus.alu_ready   = !alu_full;
  assign bus.ld_ready    = !ld_full;
  assign bus.rg_wrt_en   = wrt_en;
  assign bus.rg_wrt_addr = wrt_addr;
  assign bus.rg_wrt_data = wrt_data;
  assign bus.query_hit   = (bus.query_addr != {REG_AW{1'b0}})
                         && (pending_hit || (wrt_en && (wrt_addr == bus.query_addr)));
  assign bus.busy        = !alu_empty || !ld_empty || wrt_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-source scoreboards filled on accepted
// handshakes and drained by every observed register-file write.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          wr_count    = 0;
  logic [36:0] alu_q[$];
  logic [36:0] ld_q[$];
  bit          src_log[$];
  logic [36:0] obs_w, exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: check writes against source queue heads, then record accepts.
  always @(negedge clk) begin
    if (bus.rg_wrt_en === 1'b1) begin
      obs_w = {bus.rg_wrt_addr, bus.rg_wrt_data};
      wr_count++;
      if (ld_q.size() > 0 && ld_q[0] === obs_w) begin
        exp_w = ld_q.pop_front();
        src_log.push_back(1'b1);
      end else if (alu_q.size() > 0) begin
        exp_w = alu_q.pop_front();
        src_log.push_back(1'b0);
      end else begin
        exp_w = {37{1'bx}};
      end
      chk("write", 64'(obs_w), 64'(exp_w));
    end
    if (reset === 1'b0) begin
      alu_q.delete();
      ld_q.delete();
    end else begin
      if (bus.alu_valid && bus.alu_ready && bus.alu_rd != 5'd0)
        alu_q.push_back({bus.alu_rd, bus.alu_data});
      if (bus.ld_valid && bus.ld_ready && bus.ld_rd != 5'd0)
        ld_q.push_back({bus.ld_rd, bus.ld_data});
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(bus.busy), 64'd0);
  endtask

  // Both producers offer; LSU never runs dry, ALU offers n_alu entries.
  task automatic drive_both(input int n_alu, input int n_cyc, input bit chk_full,
                            input logic [31:0] abase, input logic [31:0] lbase,
                            output int a_sent);
    int l_sent = 0;
    bit a_acc, l_acc;
    bit full_checked = 1'b0;
    a_sent        = 0;
    bus.alu_valid = (n_alu > 0);
    bus.alu_rd    = 5'd1;
    bus.alu_data  = abase;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd17;
    bus.ld_data   = lbase;
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clk);
      if (chk_full && a_sent == 2 && !full_checked) begin
        chk("alu_ready_when_full", 64'(bus.alu_ready), 64'd0);
        full_checked = 1'b1;
      end
      a_acc = bus.alu_valid && bus.alu_ready;
      l_acc = bus.ld_valid && bus.ld_ready;
      tick();
      if (a_acc) begin
        a_sent++;
        bus.alu_rd    = 5'(1 + a_sent % 15);
        bus.alu_data  = abase + 32'(a_sent);
        bus.alu_valid = (a_sent < n_alu);
      end
      if (l_acc) begin
        l_sent++;
        bus.ld_rd   = 5'(17 + l_sent % 15);
        bus.ld_data = lbase + 32'(l_sent);
      end
    end
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          a_sent;
    int          wr_base;
    logic [14:0] seq_obs, seq_exp;

    reset          = 1'b0;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd5;
    bus.alu_data   = 32'h0000_0055;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = 5'd0;
    bus.ld_data    = 32'd0;
    bus.query_addr = 5'd5;

    // Reset held with ALU offering.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wrt_en", 64'(bus.rg_wrt_en), 64'd0);
    chk("reset_query_hit", 64'(bus.query_hit), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_wrt_addr", 64'(bus.rg_wrt_addr), 64'd0);
    tick();
    reset         = 1'b1;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("post_reset_ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("post_reset_busy", 64'(bus.busy), 64'd0);

    // Single ALU write and its latency.
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("single_queued_hit", 64'(bus.query_hit), 64'd1);
    chk("single_queued_en", 64'(bus.rg_wrt_en), 64'd0);
    tick();
    @(negedge clk);
    chk("single_en", 64'(bus.rg_wrt_en), 64'd1);
    chk("single_addr", 64'(bus.rg_wrt_addr), 64'd5);
    chk("single_data", 64'(bus.rg_wrt_data), 64'hDEAD_BEEF);
    chk("single_out_hit", 64'(bus.query_hit), 64'd1);
    tick();
    @(negedge clk);
    chk("single_done_en", 64'(bus.rg_wrt_en), 64'd0);
    chk("single_done_hit", 64'(bus.query_hit), 64'd0);
    chk("single_done_busy", 64'(bus.busy), 64'd0);

    // x0 load result: drained silently, addr/data still load.
    tick();
    bus.query_addr = 5'd0;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd0;
    bus.ld_data    = 32'h0000_1234;
    tick();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("x0_busy_queued", 64'(bus.busy), 64'd1);
    chk("x0_query_zero", 64'(bus.query_hit), 64'd0);
    tick();
    @(negedge clk);
    chk("x0_en", 64'(bus.rg_wrt_en), 64'd0);
    chk("x0_addr", 64'(bus.rg_wrt_addr), 64'd0);
    chk("x0_data", 64'(bus.rg_wrt_data), 64'h0000_1234);
    chk("x0_busy_done", 64'(bus.busy), 64'd0);

    // Sustained contention: LSU x4 then ALU, repeating.
    tick();
    src_log.delete();
    drive_both(1000, 25, 1'b0, 32'hA000_0000, 32'hB000_0000, a_sent);
    wait_idle("contention_idle");
    for (int i = 0; i < 15; i++) begin
      seq_exp[i] = (i % 5 == 4) ? 1'b0 : 1'b1;
      seq_obs[i] = (i < src_log.size()) ? src_log[i] : 1'bx;
    end
    chk("contention_sequence", 64'(seq_obs), 64'(seq_exp));

    // Backpressure: three ALU entries against a saturating LSU.
    tick();
    drive_both(3, 14, 1'b1, 32'hC000_0000, 32'hD000_0000, a_sent);
    wait_idle("backpressure_idle");
    chk("backpressure_alu_accepted", 64'(a_sent), 64'd3);
    chk("backpressure_drained", 64'(alu_q.size() + ld_q.size()), 64'd0);

    // Reset with two LSU entries in flight.
    tick();
    bus.query_addr = 5'd8;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd7;
    bus.ld_data    = 32'h0000_0077;
    tick();
    bus.ld_rd   = 5'd8;
    bus.ld_data = 32'h0000_0088;
    tick();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("midflight_pending_hit", 64'(bus.query_hit), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    wr_base = wr_count;
    chk("midreset_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("midreset_ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("midreset_en", 64'(bus.rg_wrt_en), 64'd0);
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_hit", 64'(bus.query_hit), 64'd0);
    repeat (6) @(negedge clk);
    chk("midreset_no_writes", 64'(wr_count - wr_base), 64'd0);
    chk("final_scoreboard_empty", 64'(alu_q.size() + ld_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
